// File: rtl/oversample_window.sv
// oversample_window: gathers W=SAMPLES*OSF oversampled bits into a window with a valid/ready handoff.
// Optional sticky overrun flag when OVERSAMPLE_WINDOW_OVERRUN_EN is defined.
module oversample_window #(
    parameter int SAMPLES = 2,
    parameter int OSF = 8,
    localparam int W = SAMPLES * OSF,
    localparam int CW = $clog2(W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          tick,
    input  logic          data_in,
    input  logic          ready,
    output logic [W-1:0]  window,
    output logic          valid,
    output logic [CW-1:0] count
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
    ,
    output logic          overrun
`endif
);
    typedef enum logic {IDLE, FILL} state_t;
    state_t state;
    logic [W-1:0] shift;
    logic [W-1:0] next_shift;
    logic capture;
    logic done;
    assign capture = state == FILL && enable && tick;
    assign next_shift = {shift[W-2:0], data_in};
    assign done = capture && count == CW'(W - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            count <= '0;
            window <= '0;
            valid <= 1'b0;
        end else begin
            state <= enable ? FILL : IDLE;
            shift <= !enable ? '0 : capture ? next_shift : shift;
            count <= !enable || done ? '0 : capture ? count + CW'(1) : count;
            // a completion while the held window is still unconsumed is dropped
            if (done && (!valid || ready)) begin
                window <= next_shift;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
    always_ff @(posedge clock)
        overrun <= reset ? 1'b0 : overrun | (done && valid && !ready);
`endif
endmodule

// File: tb/tb_oversample_window.sv
// tb_oversample_window: scenario tasks with a scoreboard of windows expected at each transfer.
module tb_oversample_window;
    localparam int W = 16;
    logic clk, reset, enable, tick, data_in, ready;
    logic [W-1:0] window;
    logic valid;
    logic [3:0] count;
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
    logic overrun;
`endif
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;

    oversample_window #(.SAMPLES(2), .OSF(8)) dut (
        .clock(clk),
        .reset(reset),
        .enable(enable),
        .tick(tick),
        .data_in(data_in),
        .ready(ready),
        .window(window),
        .valid(valid),
        .count(count)
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // every accepted transfer must match the oldest window the bench expects
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL transfer: got unexpected window %h, required none", window);
            end else begin
                exp_w = exp_q.pop_front();
                if (window !== exp_w) begin
                    miscompares++;
                    $display("FAIL transfer: got window %h, required %h", window, exp_w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            data_in = w[i];
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        step();
        ready = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL consume_valid: got %b, required 0", valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; tick = 1'b1; data_in = 1'b1; ready = 1'b1;
        step();
        step();
        reset = 1'b0; enable = 1'b0; tick = 1'b0; data_in = 1'b0; ready = 1'b0;
        vectors++;
        if ({window, valid, count} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got window %h valid %b count %0d, required 0", window, valid, count);
        end
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overrun: got %b, required 0", overrun);
        end
`endif
    endtask

    task automatic test_fill();
        enable = 1'b1; tick = 1'b1; data_in = 1'b0;
        step();
        send(16'hFFFF, 15);
        vectors++;
        if (valid !== 1'b0 || count !== 4'd15) begin
            miscompares++;
            $display("FAIL fill_partial: got valid %b count %0d, required 0 and 15", valid, count);
        end
        send(16'h0001, 1);
        vectors++;
        if (valid !== 1'b1 || window !== 16'hFFFF || count !== 4'd0) begin
            miscompares++;
            $display("FAIL fill_done: got valid %b window %h count %0d, required 1 ffff 0", valid, window, count);
        end
        exp_q.push_back(16'hFFFF);
        consume();
    endtask

    task automatic test_order();
        send(16'h0001, 16);
        vectors++;
        if (valid !== 1'b1 || window !== 16'h0001) begin
            miscompares++;
            $display("FAIL order: got valid %b window %h, required 1 0001", valid, window);
        end
        exp_q.push_back(16'h0001);
        consume();
    endtask

    task automatic test_overrun();
        send(16'hAAAA, 16);
        send(16'hAAAA, 16);
        vectors++;
        if (valid !== 1'b1 || window !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL overrun_hold: got valid %b window %h, required 1 aaaa", valid, window);
        end
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag: got %b, required 1", overrun);
        end
`endif
        exp_q.push_back(16'hAAAA);
        consume();
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        send(16'h1234, 16);
        exp_q.push_back(16'h1234);
        for (int i = 15; i >= 0; i--) begin
            logic [W-1:0] b = 16'hC3A5;
            data_in = b[i];
            tick = 1'b1;
            ready = i == 0;
            step();
        end
        tick = 1'b0;
        ready = 1'b0;
        vectors++;
        if (valid !== 1'b1 || window !== 16'hC3A5) begin
            miscompares++;
            $display("FAIL back_to_back: got valid %b window %h, required 1 c3a5", valid, window);
        end
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_overrun: got %b, required 0", overrun);
        end
`endif
        exp_q.push_back(16'hC3A5);
        consume();
    endtask

    task automatic test_enable_drop();
        send(16'h001F, 5);
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL drop_partial: got count %0d, required 5", count);
        end
        enable = 1'b0; tick = 1'b1;
        step();
        tick = 1'b0;
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL drop_count: got count %0d, required 0", count);
        end
        enable = 1'b1;
        step();
        send(16'h5A0F >> 1, 15);
        vectors++;
        if (valid !== 1'b0 || count !== 4'd15) begin
            miscompares++;
            $display("FAIL drop_refill: got valid %b count %0d, required 0 and 15", valid, count);
        end
        send(16'h5A0F, 1);
        vectors++;
        if (valid !== 1'b1 || window !== 16'h5A0F) begin
            miscompares++;
            $display("FAIL drop_window: got valid %b window %h, required 1 5a0f", valid, window);
        end
        exp_q.push_back(16'h5A0F);
        consume();
    endtask

    task automatic test_reset_pending();
        send(16'h7E81, 16);
        send(16'h0000, 7);
        vectors++;
        if (valid !== 1'b1 || count !== 4'd7) begin
            miscompares++;
            $display("FAIL pending_setup: got valid %b count %0d, required 1 and 7", valid, count);
        end
        reset = 1'b1; ready = 1'b1; tick = 1'b1;
        step();
        reset = 1'b0; ready = 1'b0; tick = 1'b0;
        vectors++;
        if ({window, valid, count} !== 21'd0) begin
            miscompares++;
            $display("FAIL pending_reset: got window %h valid %b count %0d, required 0", window, valid, count);
        end
`ifdef OVERSAMPLE_WINDOW_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_overrun: got %b, required 0", overrun);
        end
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d windows left, required 0", exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tick = 1'b0; data_in = 1'b0; ready = 1'b0;
        test_reset();
        test_fill();
        test_order();
        test_overrun();
        test_back_to_back();
        test_enable_drop();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
